// File: rtl/riscv_core_mul_div_arb.sv
// Round-robin arbiter that shares one mul/div unit between two requesters.
// It latches the operands, issues a single-cycle start pulse, and holds the result until the owner takes it.
module riscv_core_mul_div_arb #(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              i_mul_div_arb_clk,
  input  logic              i_mul_div_arb_rst,
  input  logic [1:0]        i_mul_div_arb_req_valid,
  input  logic [2*XLEN-1:0] i_mul_div_arb_req_srcA,
  input  logic [2*XLEN-1:0] i_mul_div_arb_req_srcB,
  input  logic [5:0]        i_mul_div_arb_req_control,
  input  logic [1:0]        i_mul_div_arb_req_isword,
  output logic [1:0]        o_mul_div_arb_req_ready,
  input  logic [1:0]        i_mul_div_arb_flush,
  output logic [1:0]        o_mul_div_arb_rsp_valid,
  output logic [XLEN-1:0]   o_mul_div_arb_rsp_result,
  output logic              o_mul_div_arb_rsp_div_by_zero,
  output logic              o_mul_div_arb_rsp_overflow,
  output logic              o_mul_div_arb_rsp_timeout,
  input  logic [1:0]        i_mul_div_arb_rsp_ready,
  output logic              o_mul_div_arb_mdu_en,
  output logic [XLEN-1:0]   o_mul_div_arb_mdu_srcA,
  output logic [XLEN-1:0]   o_mul_div_arb_mdu_srcB,
  output logic [2:0]        o_mul_div_arb_mdu_control,
  output logic              o_mul_div_arb_mdu_isword,
  input  logic              i_mul_div_arb_mdu_busy,
  input  logic              i_mul_div_arb_mdu_done,
  input  logic [XLEN-1:0]   i_mul_div_arb_mdu_result,
  input  logic              i_mul_div_arb_mdu_div_by_zero,
  input  logic              i_mul_div_arb_mdu_overflow,
  output logic              o_mul_div_arb_busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam int             WDW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYC - 1);

  logic [2:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic            drop_q, drop_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [XLEN-1:0] srca_q, srca_d;
  logic [XLEN-1:0] srcb_q, srcb_d;
  logic [2:0]      ctl_q, ctl_d;
  logic            isword_q, isword_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;
  logic            tmo_q, tmo_d;

  logic [1:0] elig_s;
  logic       grant_vld_s;
  logic       grant_idx_s;
  logic       own_flush_s;
  logic       own_ready_s;
  logic       drop_eff_s;

  // Arbitration and owner-side decode
  always_comb begin
    elig_s      = i_mul_div_arb_req_valid & ~i_mul_div_arb_flush;
    grant_vld_s = (state_q == ST_IDLE) && !i_mul_div_arb_mdu_busy &&
                  (elig_s != 2'b00) && !i_mul_div_arb_rst;
    if (elig_s == 2'b11) begin
      grant_idx_s = rr_q;
    end else begin
      grant_idx_s = elig_s[1];
    end
    own_flush_s = owner_q ? i_mul_div_arb_flush[1] : i_mul_div_arb_flush[0];
    own_ready_s = owner_q ? i_mul_div_arb_rsp_ready[1] : i_mul_div_arb_rsp_ready[0];
    // A flush arriving in the same cycle as done must already suppress the response
    drop_eff_s  = drop_q | own_flush_s;
  end

  // Next-state logic for the sequencing FSM and its datapath registers
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    drop_d   = drop_q;
    wdog_d   = wdog_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    ctl_d    = ctl_q;
    isword_d = isword_q;
    res_d    = res_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld_s) begin
          owner_d  = grant_idx_s;
          rr_d     = ~grant_idx_s;
          srca_d   = grant_idx_s ? i_mul_div_arb_req_srcA[2*XLEN-1:XLEN] : i_mul_div_arb_req_srcA[XLEN-1:0];
          srcb_d   = grant_idx_s ? i_mul_div_arb_req_srcB[2*XLEN-1:XLEN] : i_mul_div_arb_req_srcB[XLEN-1:0];
          ctl_d    = grant_idx_s ? i_mul_div_arb_req_control[5:3] : i_mul_div_arb_req_control[2:0];
          isword_d = grant_idx_s ? i_mul_div_arb_req_isword[1] : i_mul_div_arb_req_isword[0];
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = {WDW{1'b0}};
        tmo_d   = 1'b0;
        drop_d  = drop_eff_s;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        drop_d = drop_eff_s;
        if (i_mul_div_arb_mdu_done) begin
          if (drop_eff_s) begin
            drop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            res_d   = i_mul_div_arb_mdu_result;
            dbz_d   = i_mul_div_arb_mdu_div_by_zero;
            ovf_d   = i_mul_div_arb_mdu_overflow;
            tmo_d   = 1'b0;
            state_d = ST_RESP;
          end
        end else if (wdog_q == WDOG_LAST) begin
          res_d   = {XLEN{1'b0}};
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = drop_eff_s ? ST_DRAIN : ST_RESP;
        end else begin
          wdog_d  = wdog_q + WDW'(1);
        end
      end
      ST_DRAIN: begin
        // The unit cannot abort, so wait until it is quiet before re-arbitrating
        if (i_mul_div_arb_mdu_done || !i_mul_div_arb_mdu_busy) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_RESP: begin
        if (own_ready_s || own_flush_s) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        drop_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_mul_div_arb_clk) begin
    if (i_mul_div_arb_rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      drop_q   <= 1'b0;
      wdog_q   <= {WDW{1'b0}};
      srca_q   <= {XLEN{1'b0}};
      srcb_q   <= {XLEN{1'b0}};
      ctl_q    <= 3'b000;
      isword_q <= 1'b0;
      res_q    <= {XLEN{1'b0}};
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      drop_q   <= drop_d;
      wdog_q   <= wdog_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      ctl_q    <= ctl_d;
      isword_q <= isword_d;
      res_q    <= res_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_mul_div_arb_req_ready       = grant_vld_s ? (grant_idx_s ? 2'b10 : 2'b01) : 2'b00;
  assign o_mul_div_arb_rsp_valid       = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_mul_div_arb_rsp_result      = res_q;
  assign o_mul_div_arb_rsp_div_by_zero = dbz_q;
  assign o_mul_div_arb_rsp_overflow    = ovf_q;
  assign o_mul_div_arb_rsp_timeout     = tmo_q;
  assign o_mul_div_arb_mdu_en          = (state_q == ST_ISSUE);
  assign o_mul_div_arb_mdu_srcA        = srca_q;
  assign o_mul_div_arb_mdu_srcB        = srcb_q;
  assign o_mul_div_arb_mdu_control     = ctl_q;
  assign o_mul_div_arb_mdu_isword      = isword_q;
  assign o_mul_div_arb_busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_riscv_core_mul_div_arb.sv
// Scoreboard bench for riscv_core_mul_div_arb: directed requests, a behavioural mul/div unit,
// and a monitor that checks grants and responses against queued expectations.
module tb_riscv_core_mul_div_arb;
  localparam int XLEN = 64;
  localparam int TCYC = 8;

  typedef struct packed {
    logic [63:0] res;
    logic        dbz;
    logic        ovf;
    logic        tmo;
  } rsp_t;

  logic        clk, rst;
  logic        rv0, rv1;
  logic [63:0] a0, b0, a1, b1;
  logic [2:0]  c0, c1;
  logic [1:0]  flush, rsp_ready;
  logic [1:0]  req_ready, rsp_valid;
  logic [63:0] rsp_result;
  logic        rsp_dbz, rsp_ovf, rsp_tmo;
  logic        mdu_en, mdu_w, mdu_busy, mdu_done, mdu_dbz, mdu_ovf, busy;
  logic [63:0] mdu_a, mdu_b, mdu_res;
  logic [2:0]  mdu_ctl;
  logic [204:0] all_outs;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   grant_cyc = 0, en_cyc = 0, done_cyc = 0, rsp_cyc = 0;
  int   mdl_k = 3;
  logic mdl_hang = 1'b0;
  rsp_t q0[$];
  rsp_t q1[$];
  int   grant_q[$];

  riscv_core_mul_div_arb #(.XLEN(XLEN), .TIMEOUT_CYC(TCYC)) dut (
    .i_mul_div_arb_clk            (clk),
    .i_mul_div_arb_rst            (rst),
    .i_mul_div_arb_req_valid      ({rv1, rv0}),
    .i_mul_div_arb_req_srcA       ({a1, a0}),
    .i_mul_div_arb_req_srcB       ({b1, b0}),
    .i_mul_div_arb_req_control    ({c1, c0}),
    .i_mul_div_arb_req_isword     (2'b00),
    .o_mul_div_arb_req_ready      (req_ready),
    .i_mul_div_arb_flush          (flush),
    .o_mul_div_arb_rsp_valid      (rsp_valid),
    .o_mul_div_arb_rsp_result     (rsp_result),
    .o_mul_div_arb_rsp_div_by_zero(rsp_dbz),
    .o_mul_div_arb_rsp_overflow   (rsp_ovf),
    .o_mul_div_arb_rsp_timeout    (rsp_tmo),
    .i_mul_div_arb_rsp_ready      (rsp_ready),
    .o_mul_div_arb_mdu_en         (mdu_en),
    .o_mul_div_arb_mdu_srcA       (mdu_a),
    .o_mul_div_arb_mdu_srcB       (mdu_b),
    .o_mul_div_arb_mdu_control    (mdu_ctl),
    .o_mul_div_arb_mdu_isword     (mdu_w),
    .i_mul_div_arb_mdu_busy       (mdu_busy),
    .i_mul_div_arb_mdu_done       (mdu_done),
    .i_mul_div_arb_mdu_result     (mdu_res),
    .i_mul_div_arb_mdu_div_by_zero(mdu_dbz),
    .i_mul_div_arb_mdu_overflow   (mdu_ovf),
    .o_mul_div_arb_busy           (busy)
  );

  assign all_outs = {req_ready, rsp_valid, rsp_result, rsp_dbz, rsp_ovf, rsp_tmo,
                     mdu_en, mdu_a, mdu_b, mdu_ctl, mdu_w, busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural mul/div unit: {ovf, dbz, result}
  function automatic logic [65:0] mdu_calc(input logic [63:0] a, input logic [63:0] b, input logic [2:0] ctl);
    logic [63:0] r;
    logic        z, o;
    z = 1'b0;
    o = 1'b0;
    if (!ctl[2]) begin
      r = a * b;
    end else if (b == 64'd0) begin
      r = 64'hFFFF_FFFF_FFFF_FFFF;
      z = 1'b1;
    end else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      r = a;
      o = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
    end
    return {o, z, r};
  endfunction

  int          m_cnt;
  logic [65:0] m_out;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
    end else if (mdu_en && !mdl_hang) begin
      m_cnt <= mdl_k;
      m_out <= mdu_calc(mdu_a, mdu_b, mdu_ctl);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign mdu_busy = (m_cnt != 0);
  assign mdu_done = (m_cnt == 1);
  assign mdu_res  = mdu_done ? m_out[63:0] : 64'hDEAD_BEEF_DEAD_BEEF;
  assign mdu_dbz  = mdu_done & m_out[64];
  assign mdu_ovf  = mdu_done & m_out[65];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_rsp(input int n, input logic [63:0] r, input logic z, input logic o, input logic t);
    rsp_t e;
    e = '{res: r, dbz: z, ovf: o, tmo: t};
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Drive a request until accepted; returns just after the accepting clock edge
  task automatic send(input int n, input logic [63:0] a, input logic [63:0] b, input logic [2:0] ctl);
    int t;
    if (n == 0) begin a0 = a; b0 = b; c0 = ctl; rv0 = 1'b1; end
    else        begin a1 = a; b1 = b; c1 = ctl; rv1 = 1'b1; end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[n] && t < 200);
    if (!req_ready[n]) begin
      errors++;
      $display("FAIL grant_timeout req%0d got no req_ready want req_ready", n);
    end
    @(posedge clk);
    #1;
    if (n == 0) rv0 = 1'b0;
    else        rv1 = 1'b0;
  endtask

  task automatic wait_en();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mdu_en && t < 200);
    if (!mdu_en) begin
      errors++;
      $display("FAIL mdu_en_timeout got 0 want 1");
    end
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid[n] && t < 200);
    if (!rsp_valid[n]) begin
      errors++;
      $display("FAIL rsp_timeout req%0d got 0 want 1", n);
    end
  endtask

  // Monitor: grant order, response contents and one-hot properties
  initial begin
    logic [1:0] prev_rv;
    rsp_t       e;
    int         g;
    prev_rv = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready == 2'b11) begin
          errors++;
          $display("FAIL req_ready_onehot got %b want one-hot", req_ready);
        end
        if (req_ready != 2'b00) begin
          grant_cyc = cyc;
          if (grant_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant got %b want none", req_ready);
          end else begin
            g = grant_q.pop_front();
            vectors++;
            if (int'(req_ready[1]) != g) begin
              errors++;
              $display("FAIL grant_order got req%0d want req%0d", int'(req_ready[1]), g);
            end
          end
        end
        if (mdu_en)   en_cyc   = cyc;
        if (mdu_done) done_cyc = cyc;
        if (rsp_valid != 2'b00 && prev_rv == 2'b00) rsp_cyc = cyc;
        if (rsp_valid == 2'b11) begin
          errors++;
          $display("FAIL rsp_valid_onehot got %b want one-hot", rsp_valid);
        end
        for (int n = 0; n < 2; n++) begin
          if (rsp_valid[n]) begin
            if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
              errors++;
              $display("FAIL unexpected_rsp%0d got valid want idle", n);
            end else if (rsp_ready[n]) begin
              e = (n == 0) ? q0.pop_front() : q1.pop_front();
              vectors++;
              if ({rsp_result, rsp_dbz, rsp_ovf, rsp_tmo} !== e) begin
                errors++;
                $display("FAIL rsp%0d got res=%h dbz=%b ovf=%b tmo=%b want res=%h dbz=%b ovf=%b tmo=%b",
                         n, rsp_result, rsp_dbz, rsp_ovf, rsp_tmo, e.res, e.dbz, e.ovf, e.tmo);
              end
            end
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  initial begin
    int t;
    rst = 1'b1; rv0 = 1'b0; rv1 = 1'b0; flush = 2'b00; rsp_ready = 2'b11;
    a0 = 64'd0; b0 = 64'd0; a1 = 64'd0; b1 = 64'd0; c0 = 3'b000; c1 = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 256'(all_outs), 256'd0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: MUL 3*5, k=3
    grant_q.push_back(0);
    expect_rsp(0, 64'd15, 1'b0, 1'b0, 1'b0);
    send(0, 64'd3, 64'd5, 3'b000);
    repeat (8) @(posedge clk); #1;
    check("t1_en_latency",  256'(en_cyc - grant_cyc), 256'd1);
    check("t1_rsp_latency", 256'(rsp_cyc - grant_cyc), 256'd5);

    // Divide by zero from requester 1 (leaves rr pointer at 0)
    grant_q.push_back(1);
    expect_rsp(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send(1, 64'd7, 64'd0, 3'b100);
    repeat (8) @(posedge clk); #1;

    // T2: both requesters continuously valid
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
    expect_rsp(0, 64'd42, 1'b0, 1'b0, 1'b0);
    expect_rsp(0, 64'h1_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    expect_rsp(1, 64'd25, 1'b0, 1'b0, 1'b0);
    expect_rsp(1, 64'd81, 1'b0, 1'b0, 1'b0);
    fork
      begin send(0, 64'd6, 64'd7, 3'b000); send(0, 64'hFFFF_FFFF, 64'd2, 3'b000); end
      begin send(1, 64'd100, 64'd4, 3'b100); send(1, 64'd9, 64'd9, 3'b000); end
    join
    repeat (10) @(posedge clk); #1;

    // T3: owner 0 stalls its response; requester 1 must wait
    rsp_ready = 2'b10;
    grant_q.push_back(0); grant_q.push_back(1);
    expect_rsp(0, 64'd143, 1'b0, 1'b0, 1'b0);
    expect_rsp(1, 64'd60, 1'b0, 1'b0, 1'b0);
    fork
      send(0, 64'd11, 64'd13, 3'b000);
      begin wait_rsp(0); send(1, 64'd20, 64'd3, 3'b000); end
      begin
        wait_rsp(0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("t3_hold", 256'({rsp_valid, rsp_result, req_ready}), 256'({2'b01, 64'd143, 2'b00}));
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
      end
    join
    repeat (10) @(posedge clk); #1;

    // T4: flush owner 0 during WAIT; pending requester 1 granted right after done
    mdl_k = 4;
    grant_q.push_back(0); grant_q.push_back(1);
    expect_rsp(1, 64'd30, 1'b0, 1'b0, 1'b0);
    fork
      send(0, 64'd2, 64'd2, 3'b000);
      begin wait_en(); @(posedge clk); #1 flush = 2'b01; @(posedge clk); #1 flush = 2'b00; end
      begin wait_en(); send(1, 64'd5, 64'd6, 3'b000); end
    join
    check("t4_grant_after_done", 256'(grant_cyc - done_cyc), 256'd1);
    repeat (12) @(posedge clk); #1;

    // T5: unit never completes -> timeout response after TCYC WAIT cycles
    mdl_hang = 1'b1;
    grant_q.push_back(0);
    expect_rsp(0, 64'd0, 1'b0, 1'b0, 1'b1);
    send(0, 64'd1, 64'd1, 3'b000);
    repeat (14) @(posedge clk); #1;
    check("t5_timeout_latency", 256'(rsp_cyc - en_cyc), 256'(TCYC + 1));
    mdl_hang = 1'b0;

    // Signed overflow with minimum latency k=1; timeout flag must be clear again
    mdl_k = 1;
    grant_q.push_back(1);
    expect_rsp(1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    send(1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100);
    repeat (6) @(posedge clk); #1;
    check("ovf_rsp_latency", 256'(rsp_cyc - grant_cyc), 256'd3);

    // T6: reset in WAIT abandons the op silently
    mdl_k = 5;
    grant_q.push_back(0);
    send(0, 64'd4, 64'd4, 3'b000);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_reset_outputs", 256'(all_outs), 256'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    mdl_k = 2;
    grant_q.push_back(1);
    expect_rsp(1, 64'd64, 1'b0, 1'b0, 1'b0);
    send(1, 64'd8, 64'd8, 3'b000);

    t = 0;
    while ((q0.size() + q1.size() + grant_q.size()) != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("queues_drained", 256'(q0.size() + q1.size() + grant_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
